// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request scheduler: FSM encoding,
// opcode map and the request payload.
package alu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned OPER_W   = 4;
  localparam int unsigned NREQ_DEF = 2;
  localparam int unsigned OPER_MAX = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [OPER_W-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_INC = 4'd9,
    OP_DEC = 4'd10,
    OP_MUL = 4'd11
  } oper_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OPER_W-1:0] oper;
  } req_t;

  // Opcode 0 is reserved as NOP; anything above the implemented maximum is rejected.
  function automatic logic oper_valid(input logic [OPER_W-1:0] op, input int unsigned max_op);
    return (op != '0) && (32'(op) <= max_op);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Signal bundle between the scheduler and its requesters, consumer and ALU.
interface alu_scheduler_if;
  import alu_pkg::*;

  logic [NREQ_DEF-1:0]        req_valid;
  logic [NREQ_DEF-1:0]        req_ready;
  logic [NREQ_DEF*DATA_W-1:0] req_a;
  logic [NREQ_DEF*DATA_W-1:0] req_b;
  logic [NREQ_DEF*OPER_W-1:0] req_oper;
  logic                       resp_valid;
  logic                       resp_ready;
  logic                       resp_src;
  logic [DATA_W-1:0]          resp_data;
  logic                       resp_err;
  logic                       alu_en;
  logic [DATA_W-1:0]          alu_a;
  logic [DATA_W-1:0]          alu_b;
  logic [OPER_W-1:0]          alu_oper;
  logic [DATA_W-1:0]          alu_q;
  logic                       busy;

  // Environment side: requesters, result consumer and the ALU itself.
  modport master (
    output req_valid, req_a, req_b, req_oper, resp_ready, alu_q,
    input  req_ready, resp_valid, resp_src, resp_data, resp_err,
           alu_en, alu_a, alu_b, alu_oper, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_oper, resp_ready, alu_q,
    output req_ready, resp_valid, resp_src, resp_data, resp_err,
           alu_en, alu_a, alu_b, alu_oper, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the last winner on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;
  logic last;

  // Priority goes to the requester named by ptr, the other one takes any leftover slot.
  always_comb begin
    grant = 2'b00;
    if (ptr) begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end else begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= 1'b0;
      last <= 1'b0;
    end else begin
      if (|grant) last <= grant[1];
      if (advance) ptr <= ~last;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered ALU between two requesters: arbitrate, issue, wait
// one cycle for the result, then hold the response until it is accepted.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned OPER_MAX = alu_pkg::OPER_MAX,
  parameter int unsigned NREQ     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OPER_W-1:0] req_oper,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_src,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic                   alu_en,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OPER_W-1:0]      alu_oper,
  input  logic [DATA_W-1:0]      alu_q,
  output logic                   busy
);

  state_t          state;
  logic [1:0]      arb_req;
  logic [1:0]      grant;
  logic            advance;
  logic            sel_idx;
  logic            sel_ok;
  req_t            sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (advance),
    .grant   (grant)
  );

  // Requests are only visible to the arbiter in IDLE; nothing is queued.
  always_comb begin
    arb_req  = (state == IDLE) ? req_valid[1:0] : 2'b00;
    advance  = (state == RESP) && resp_ready;
    sel_idx  = grant[1];
    sel      = '0;
    if (sel_idx) begin
      sel.a    = req_a[DATA_W +: DATA_W];
      sel.b    = req_b[DATA_W +: DATA_W];
      sel.oper = req_oper[OPER_W +: OPER_W];
    end else begin
      sel.a    = req_a[0 +: DATA_W];
      sel.b    = req_b[0 +: DATA_W];
      sel.oper = req_oper[0 +: OPER_W];
    end
    sel_ok    = oper_valid(sel.oper, OPER_MAX);
    req_ready = rst_n ? grant : '0;
  end

  // State and all registered outputs; the ALU operand registers double as the latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_src   <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      alu_en     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_oper   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            resp_src <= sel_idx;
            busy     <= 1'b1;
            if (sel_ok) begin
              state    <= ISSUE;
              alu_en   <= 1'b1;
              alu_a    <= sel.a;
              alu_b    <= sel.b;
              alu_oper <= sel.oper;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end
          end
        end
        ISSUE: begin
          alu_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          resp_data  <= alu_q;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_oper   <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural registered ALU.
module tb_alu_scheduler;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   alu_en_cnt;

  alu_scheduler_if bus ();

  alu_scheduler #(.OPER_MAX(11), .NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (bus.req_valid),
    .req_ready  (bus.req_ready),
    .req_a      (bus.req_a),
    .req_b      (bus.req_b),
    .req_oper   (bus.req_oper),
    .resp_valid (bus.resp_valid),
    .resp_ready (bus.resp_ready),
    .resp_src   (bus.resp_src),
    .resp_data  (bus.resp_data),
    .resp_err   (bus.resp_err),
    .alu_en     (bus.alu_en),
    .alu_a      (bus.alu_a),
    .alu_b      (bus.alu_b),
    .alu_oper   (bus.alu_oper),
    .alu_q      (bus.alu_q),
    .busy       (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return p[15:0];
      default: return a ^ b;
    endcase
  endfunction

  // Result is valid the cycle after alu_en is sampled; otherwise a poison value.
  always @(posedge clk) begin
    bus.alu_q <= bus.alu_en ? alu_f(bus.alu_a, bus.alu_b, bus.alu_oper) : 16'hDEAD;
    if (bus.alu_en) alu_en_cnt <= alu_en_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op);
    bus.req_a[16*i +: 16]  = a;
    bus.req_b[16*i +: 16]  = b;
    bus.req_oper[4*i +: 4] = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  int   en_before;
  logic exp_src;

  initial begin
    errors = 0; checks = 0; alu_en_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b11; bus.req_a = '0; bus.req_b = '0; bus.req_oper = '0;
    bus.resp_ready = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_src", bus.resp_src, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_alu_en", bus.alu_en, 0);
    check("rst_busy", bus.busy, 0);
    bus.req_valid = 2'b00;
    do_reset();

    // Single ADD from requester 0
    set_req(0, 16'h0003, 16'h0004, OP_ADD);
    bus.req_valid = 2'b01; #1;
    check("add_grant", bus.req_ready, 2'b01);
    check("add_idle_busy", bus.busy, 0);
    check("add_idle_alu_a", bus.alu_a, 0);
    step(); bus.req_valid = 2'b00;
    check("add_issue_en", bus.alu_en, 1);
    check("add_issue_a", bus.alu_a, 3);
    check("add_issue_b", bus.alu_b, 4);
    check("add_issue_op", bus.alu_oper, 1);
    check("add_issue_busy", bus.busy, 1);
    check("add_issue_rv", bus.resp_valid, 0);
    step();
    check("add_wait_en", bus.alu_en, 0);
    check("add_wait_rv", bus.resp_valid, 0);
    step();
    check("add_resp_valid", bus.resp_valid, 1);
    check("add_resp_src", bus.resp_src, 0);
    check("add_resp_data", bus.resp_data, 16'h0007);
    check("add_resp_err", bus.resp_err, 0);
    step();
    check("add_done_rv", bus.resp_valid, 0);
    check("add_done_busy", bus.busy, 0);
    check("add_done_alu_a", bus.alu_a, 0);

    // Invalid opcode 12 from requester 1
    en_before = alu_en_cnt;
    set_req(1, 16'h1111, 16'h2222, 4'd12);
    bus.req_valid = 2'b10; #1;
    check("inv_grant", bus.req_ready, 2'b10);
    step(); bus.req_valid = 2'b00;
    check("inv_resp_valid", bus.resp_valid, 1);
    check("inv_resp_err", bus.resp_err, 1);
    check("inv_resp_data", bus.resp_data, 0);
    check("inv_resp_src", bus.resp_src, 1);
    check("inv_alu_en", bus.alu_en, 0);
    step();
    check("inv_alu_en_cnt", alu_en_cnt, en_before);
    check("inv_done_busy", bus.busy, 0);

    // Highest valid opcode (MUL), low 16 bits only
    set_req(0, 16'h1234, 16'h0010, OP_MUL);
    bus.req_valid = 2'b01; #1;
    check("mul_grant", bus.req_ready, 2'b01);
    step(); bus.req_valid = 2'b00;
    check("mul_issue_op", bus.alu_oper, 4'd11);
    step(); step();
    check("mul_resp_valid", bus.resp_valid, 1);
    check("mul_resp_data", bus.resp_data, 16'h2340);
    check("mul_resp_err", bus.resp_err, 0);
    step();

    // Opcode 0 is invalid
    en_before = alu_en_cnt;
    set_req(0, 16'h0005, 16'h0005, OP_NOP);
    bus.req_valid = 2'b01; #1;
    step(); bus.req_valid = 2'b00;
    check("nop_resp_err", bus.resp_err, 1);
    check("nop_resp_src", bus.resp_src, 0);
    check("nop_resp_data", bus.resp_data, 0);
    step();
    check("nop_alu_en_cnt", alu_en_cnt, en_before);

    // Backpressure on a SUB from requester 1, requester 0 pending meanwhile
    set_req(1, 16'h0010, 16'h0020, OP_SUB);
    set_req(0, 16'h0001, 16'h0001, OP_ADD);
    bus.resp_ready = 1'b0;
    bus.req_valid = 2'b10; #1;
    check("bp_grant", bus.req_ready, 2'b10);
    step(); bus.req_valid = 2'b01;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", bus.resp_valid, 1);
      check("bp_resp_data", bus.resp_data, 16'hFFF0);
      check("bp_resp_src", bus.resp_src, 1);
      check("bp_resp_err", bus.resp_err, 0);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_busy", bus.busy, 1);
      step();
    end
    bus.resp_ready = 1'b1; #1;
    check("bp_hold_valid", bus.resp_valid, 1);
    step();
    check("bp_idle_busy", bus.busy, 0);
    check("bp_idle_rv", bus.resp_valid, 0);
    check("bp_idle_grant", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    step();

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    set_req(0, 16'h0001, 16'h0002, OP_ADD);
    set_req(1, 16'h0003, 16'h0005, OP_MUL);
    bus.req_valid = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      exp_src = k[0];
      check("rr_grant", bus.req_ready, exp_src ? 2'b10 : 2'b01);
      step(); step(); step();
      check("rr_resp_valid", bus.resp_valid, 1);
      check("rr_resp_src", bus.resp_src, exp_src);
      check("rr_resp_data", bus.resp_data, exp_src ? 16'h000F : 16'h0003);
      step();
    end

    // Reset while waiting on the ALU
    set_req(0, 16'h0005, 16'h0006, OP_ADD);
    bus.req_valid = 2'b01; #1;
    check("rw_grant", bus.req_ready, 2'b01);
    step(); bus.req_valid = 2'b00;
    step();
    rst_n = 1'b0; #1;
    check("rw_req_ready", bus.req_ready, 0);
    check("rw_resp_valid", bus.resp_valid, 0);
    check("rw_resp_data", bus.resp_data, 0);
    check("rw_resp_src", bus.resp_src, 0);
    check("rw_resp_err", bus.resp_err, 0);
    check("rw_alu_en", bus.alu_en, 0);
    check("rw_alu_a", bus.alu_a, 0);
    check("rw_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rw_hold_rv", bus.resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rw_after_rv", bus.resp_valid, 0);
    check("rw_after_busy", bus.busy, 0);
    set_req(1, 16'h0100, 16'h0001, OP_ADD);
    bus.req_valid = 2'b10; #1;
    check("rw_new_grant", bus.req_ready, 2'b10);
    step(); bus.req_valid = 2'b00;
    step(); step();
    check("rw_new_valid", bus.resp_valid, 1);
    check("rw_new_data", bus.resp_data, 16'h0101);
    check("rw_new_src", bus.resp_src, 1);
    check("rw_new_err", bus.resp_err, 0);
    step();
    check("rw_new_done", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter OPER_MAX, default 11, the highest opcode the ALU implements; opcodes 1..OPER_MAX are valid.
REQ-002 SHALL have parameter NREQ, default 2, the number of requesters; only 2 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 SHALL have port req_a  input  32  operandA; bits [16i+15:16i] belong to requester i.
REQ-008 SHALL have port req_b  input  32  operandB, packed as req_a.
REQ-009 SHALL have port req_oper  input  8  opcode; bits [4i+3:4i] belong to requester i.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port resp_src  output  1  index of the requester that owns the result.
REQ-013 SHALL have port resp_data  output  16  result value.
REQ-014 SHALL have port resp_err  output  1  opcode was invalid; resp_data is 0.
REQ-015 SHALL have port alu_en  output  1  ALU enable.
REQ-016 SHALL have port alu_a  output  16  ALU operandA.
REQ-017 SHALL have port alu_b  output  16  ALU operandB.
REQ-018 SHALL have port alu_oper  output  4  ALU opcode.
REQ-019 SHALL have port alu_q  input  16  registered ALU result, valid one cycle after alu_en is sampled high.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: if any req_valid bit is set, SHALL grant exactly one requester.
- Grant is round-robin; the pointer favours the requester not served last; the pointer resets to 0.
- req_ready of the winner SHALL be high combinationally in that cycle; the winner's a, b, oper and index SHALL be latched.
REQ-023 From IDLE, a valid opcode SHALL go to ISSUE; opcode 0 or greater than OPER_MAX SHALL go directly to RESP with resp_err=1 and resp_data=0, and SHALL NOT assert alu_en.
REQ-024 ISSUE (exactly 1 cycle): alu_en=1; alu_a, alu_b and alu_oper SHALL equal the latched values; next state WAIT.
REQ-025 WAIT (exactly 1 cycle): alu_en=0; alu_q SHALL be captured into the result register; next state RESP.
REQ-026 RESP: resp_valid=1 with stable resp_src, resp_data and resp_err until resp_ready is high; on the handshake, the round-robin pointer SHALL update and the next state SHALL be IDLE.
REQ-027 Request-to-resp_valid latency SHALL be 3 cycles for a valid opcode and 1 cycle for an invalid opcode; maximum throughput is one operation per 4 cycles.
REQ-028 req_ready SHALL be 0 outside IDLE; requests SHALL NOT be queued; requesters hold valid until they see ready.
REQ-029 alu_en SHALL be 0 in every state except ISSUE; alu_a, alu_b and alu_oper SHALL be 0 in IDLE.
REQ-030 resp_data SHALL be the low 16 bits from the ALU without modification, including multiply and shift results.

Reset
REQ-031 While rst_n=0, the following SHALL hold immediately: state=IDLE; req_ready=0, resp_valid=0, resp_src=0, resp_data=0, resp_err=0, alu_en=0, busy=0; RR pointer=0.
REQ-032 Reset mid-operation SHALL abandon the operation without emitting a response.

Structure
REQ-033 The FSM state encoding, the opcode constants (NOP=0, ADD=1 … MUL=11) and OPER_MAX SHALL live in a shared package, alu_pkg.
REQ-034 The 2-way round-robin arbiter SHALL be the sub-module rr_arb2 (inputs req[1:0] and advance; output grant[1:0]).

Verification
REQ-035 Single ADD: req0 a=0x0003, b=0x0004, oper=1 -> alu_en high for one cycle with alu_a=3, alu_b=4; with alu_q modelled as 7, resp_valid=1, resp_src=0, resp_data=0x0007, resp_err=0 three cycles later.
REQ-036 Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1, and each resp_src matches its grant.
REQ-037 Invalid opcode: req1 oper=12 -> alu_en never high; next cycle resp_valid=1, resp_err=1, resp_data=0, resp_src=1.
REQ-038 Backpressure: resp_ready=0 for 5 cycles -> resp fields stable, req_ready=0 and busy=1 throughout; IDLE in the cycle after resp_ready=1.
REQ-039 Reset in WAIT: rst_n low -> all outputs 0, no response; a new request after reset completes normally.
